// File: rtl/apb_dpmem_arbiter_if.sv
// rtl/apb_dpmem_arbiter_if.sv - APB bus bundle between the arbiter (master) and the dual-port memory (slave)
//
// Purpose : groups the APB request/response wires into one interface so the
//           arbiter exposes a single bus port.
// Signals : PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB  master -> slave
//           PREADY, PSLVERR, PRDATA                      slave  -> master
// Modports: master (arbiter side), slave (memory side)

interface apb_dpmem_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) ();

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PSLVERR, PRDATA
  );

endinterface

// File: rtl/apb_dpmem_arbiter.sv
// rtl/apb_dpmem_arbiter.sv - two-client round-robin APB master for a shared dual-port memory
//
// Purpose : accepts requests from two independent clients, picks a winner
//           round-robin, runs the winning request through APB SETUP/ACCESS,
//           and returns a one-cycle response (read data, slave error or
//           timeout) to the winner.
// Ports   : PCLK, PRESETn        clock and synchronous active-low reset
//           req_valid/req_ready  per-client request handshake (ready is combinational)
//           req_write/addr/wdata/strb  per-client payload, client i in slice i
//           rsp_valid            per-client one-cycle response pulse
//           rsp_rdata/err/timeout  shared response payload, valid with rsp_valid
//           apb                  APB master port (see apb_dpmem_arbiter_if)
//           busy                 high while a transfer is in SETUP or ACCESS

module apb_dpmem_arbiter #(
  parameter  int ADDR_WIDTH     = 10,
  parameter  int DATA_WIDTH     = 32,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,

  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [2*STRB_WIDTH-1:0] req_strb,

  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,

  apb_dpmem_arbiter_if.master     apb,

  output logic                    busy
);

  // Wait counter only needs to reach TIMEOUT_CYCLES-1; it saturates beyond that.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                state_q,       state_d;
  logic                  last_grant_q,  last_grant_d;
  logic                  grant_q,       grant_d;
  logic [CNT_W-1:0]      wait_cnt_q,    wait_cnt_d;

  logic                  psel_q,        psel_d;
  logic                  penable_q,     penable_d;
  logic                  pwrite_q,      pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q,       pstrb_d;

  logic [1:0]            rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_err_q,     rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  // Arbitration: a lone requester always wins; under contention the client
  // that did not win last time goes next.
  logic                  any_req;
  logic                  grant_sel;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_strb;

  always_comb begin
    any_req = |req_valid;
    if (req_valid == 2'b11) begin
      grant_sel = ~last_grant_q;
    end else begin
      grant_sel = req_valid[1];
    end
    sel_write = grant_sel ? req_write[1] : req_write[0];
    sel_addr  = grant_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : req_addr[ADDR_WIDTH-1:0];
    sel_wdata = grant_sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    sel_strb  = grant_sel ? req_strb[2*STRB_WIDTH-1:STRB_WIDTH]  : req_strb[STRB_WIDTH-1:0];
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    wait_cnt_d    = wait_cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    // Response fields are pulses: zero unless a transfer completes this edge.
    rsp_valid_d   = 2'b00;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    req_ready     = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          req_ready    = grant_sel ? 2'b10 : 2'b01;
          grant_d      = grant_sel;
          last_grant_d = grant_sel;
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          pwrite_d     = sel_write;
          paddr_d      = sel_addr;
          // Reads carry no write data and no strobes on the bus.
          pwdata_d     = sel_write ? sel_wdata : '0;
          pstrb_d      = sel_write ? sel_strb  : '0;
          state_d      = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (apb.PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = grant_q ? 2'b10 : 2'b01;
          rsp_err_d   = apb.PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : apb.PRDATA;
          state_d     = ST_IDLE;
        end else if (TO_EN && (wait_cnt_q == TO_LAST)) begin
          // Slave hung: abort and report a timeout error to the winner.
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = grant_q ? 2'b10 : 2'b01;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: park the bus and restart cleanly.
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        paddr_d   = '0;
        pwdata_d  = '0;
        pstrb_d   = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      wait_cnt_q    <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 2'b00;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      wait_cnt_q    <= wait_cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSTRB   = pstrb_q;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

  assign busy = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

endmodule
